// File: rtl/roulette_pkg.sv
// Shared types and constants for the roulette judge.
// Contents: FSM state type, position/segment constants, active-low digit
// table, and helpers that decode a lit-segment pattern to a position and a
// score digit to a 7-seg drive pattern.
package roulette_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    JUDGE   = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam int unsigned NUM_POS = 6;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned POS_W   = 3;
  localparam int unsigned SCORE_W = 4;

  localparam logic [POS_W-1:0] POS_INVALID = 3'd7;
  localparam logic [SEG_W-1:0] SEG_BLANK   = 7'h7F;

  // Active-low digits, bit0 = segment a
  localparam logic [SEG_W-1:0] DIGIT_SEG [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  // lit is active-high; only a single lit outer segment with g dark is a position
  function automatic logic [POS_W-1:0] seg_to_pos(input logic [SEG_W-1:0] lit);
    logic [POS_W-1:0] idx;
    idx = POS_INVALID;
    if (!lit[6] && $onehot(lit[5:0])) begin
      for (int unsigned i = 0; i < NUM_POS; i++) begin
        if (lit[i[2:0]]) idx = i[2:0];
      end
    end
    return idx;
  endfunction

  function automatic logic [SEG_W-1:0] digit_seg(input logic [SCORE_W-1:0] d);
    return (d < 4'd10) ? DIGIT_SEG[d] : SEG_BLANK;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter, and a
// one-cycle press pulse on the released->pressed transition.
// Ports: clk, nrst (async active low), key_n (raw, active low),
//        key_db (debounced level, 1 = released), press (1-cycle pulse).
module key_debounce
  import roulette_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 1_000_000,
  parameter int unsigned DEB_W      = 20
) (
  input  logic clk,
  input  logic nrst,
  input  logic key_n,
  output logic key_db,
  output logic press
);

  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [DEB_W-1:0] cnt;
  logic             flip_c;

  // Level is accepted only after it differs from key_db for DEB_CYCLES cycles
  assign flip_c = (sync2 != key_db) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      key_db <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= flip_c && !sync2;
      if (sync2 == key_db || flip_c) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + DEB_W'(1);
      end
      if (flip_c) key_db <= sync2;
    end
  end

endmodule

// File: rtl/roulette_judge.sv
// Roulette reader/stopper: on a debounced press captures the roulette HEX0
// drive, decodes the lit segment to a position, judges it against the guess
// and keeps a saturating score shown on an active-low 7-seg digit.
// Ports: clk, nrst, seg_in[6:0], key_n, guess[2:0] ->
//        pos[2:0], pos_valid, hit, err, score[3:0], hex_score[6:0].
// Build option: JUDGE_MISS_CLEAR_EN - a valid miss clears the score.
module roulette_judge
  import roulette_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 1_000_000,
  parameter int unsigned DEB_W      = 20,
  parameter int unsigned SCORE_MAX  = 9
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [SEG_W-1:0]   seg_in,
  input  logic               key_n,
  input  logic [POS_W-1:0]   guess,
  output logic [POS_W-1:0]   pos,
  output logic               pos_valid,
  output logic               hit,
  output logic               err,
  output logic [SCORE_W-1:0] score,
  output logic [SEG_W-1:0]   hex_score
);

  localparam logic [SCORE_W-1:0] SCORE_SAT = SCORE_W'(SCORE_MAX);

  state_t             state;
  state_t             state_d;
  logic [POS_W-1:0]   pos_d;
  logic               pos_valid_d;
  logic               hit_d;
  logic               err_d;
  logic [SCORE_W-1:0] score_d;
  logic [POS_W-1:0]   cap_pos_c;
  logic               key_db;
  logic               press;

  key_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .DEB_W      (DEB_W)
  ) u_deb (
    .clk    (clk),
    .nrst   (nrst),
    .key_n  (key_n),
    .key_db (key_db),
    .press  (press)
  );

  // seg_in is active low; invert so the lit segment reads as a 1
  assign cap_pos_c = seg_to_pos(~seg_in);

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_d;
  end

  // Next state and next output values
  always_comb begin
    state_d     = state;
    pos_d       = pos;
    pos_valid_d = pos_valid;
    hit_d       = 1'b0;
    err_d       = err;
    score_d     = score;
    case (state)
      IDLE: begin
        if (press) begin
          state_d     = CAPTURE;
          pos_valid_d = 1'b0;
        end
      end
      CAPTURE: begin
        pos_d       = cap_pos_c;
        err_d       = (cap_pos_c == POS_INVALID);
        pos_valid_d = 1'b1;
        state_d     = JUDGE;
      end
      JUDGE: begin
        if (!err && pos == guess) begin
          hit_d   = 1'b1;
          score_d = (score >= SCORE_SAT) ? SCORE_SAT : score + SCORE_W'(1);
        end
`ifdef JUDGE_MISS_CLEAR_EN
        else if (!err) begin
          score_d = '0;
        end
`endif
        state_d = HOLD;
      end
      HOLD: begin
        // Wait for release so a held key yields a single judgement
        if (key_db) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output registers; hex_score trails score by one cycle
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pos       <= '0;
      pos_valid <= 1'b0;
      hit       <= 1'b0;
      err       <= 1'b0;
      score     <= '0;
      hex_score <= 7'b1000000;
    end else begin
      pos       <= pos_d;
      pos_valid <= pos_valid_d;
      hit       <= hit_d;
      err       <= err_d;
      score     <= score_d;
      hex_score <= digit_seg(score);
    end
  end

endmodule

// File: tb/tb_roulette_judge.sv
// Directed self-checking bench for roulette_judge (DEB_CYCLES=16, DEB_W=5).
module tb_roulette_judge;
  import roulette_pkg::*;

  logic       clk = 1'b0;
  logic       nrst;
  logic [6:0] seg_in;
  logic       key_n;
  logic [2:0] guess;
  logic [2:0] pos;
  logic       pos_valid;
  logic       hit;
  logic       err;
  logic [3:0] score;
  logic [6:0] hex_score;

  int checks = 0;
  int errors = 0;
  int cap_cnt = 0;
  int exp_score = 0;

  logic [6:0] exp_digit [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  roulette_judge #(
    .DEB_CYCLES (16),
    .DEB_W      (5),
    .SCORE_MAX  (9)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .seg_in    (seg_in),
    .key_n     (key_n),
    .guess     (guess),
    .pos       (pos),
    .pos_valid (pos_valid),
    .hit       (hit),
    .err       (err),
    .score     (score),
    .hex_score (hex_score)
  );

  always #5 clk = ~clk;

  // Each capture occupies exactly one cycle in CAPTURE
  always @(posedge clk) begin
    if (nrst && dut.state == CAPTURE) cap_cnt <= cap_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_press(output logic found);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk); #1;
      if (dut.u_deb.press) found = 1'b1;
    end
  endtask

  task automatic do_press(input logic [6:0] seg, input logic [2:0] g,
                          input logic [2:0] exp_pos, input int hold);
    int   base;
    logic found;
    logic exp_err;
    logic exp_hit;
    seg_in  = seg;
    guess   = g;
    base    = cap_cnt;
    key_n   = 1'b0;
    exp_err = (exp_pos == 3'd7);
    exp_hit = !exp_err && (exp_pos == g);
    wait_press(found);
    if (!found) begin
      check("press_seen", 32'(found), 32'(1));
      key_n = 1'b1;
      return;
    end
    @(posedge clk); #1;                                     // P+1
    check("cap_state", 32'(dut.state), 32'(CAPTURE));
    check("cap_pos_valid", 32'(pos_valid), 32'(0));
    @(posedge clk); #1;                                     // P+2
    check("judge_pos_valid", 32'(pos_valid), 32'(1));
    check("judge_pos", 32'(pos), 32'(exp_pos));
    check("judge_err", 32'(err), 32'(exp_err));
    check("judge_hit_early", 32'(hit), 32'(0));
    if (exp_hit) exp_score = (exp_score >= 9) ? 9 : exp_score + 1;
`ifdef JUDGE_MISS_CLEAR_EN
    else if (!exp_err) exp_score = 0;
`endif
    @(posedge clk); #1;                                     // P+3
    check("hit_pulse", 32'(hit), 32'(exp_hit));
    check("score", 32'(score), 32'(exp_score));
    @(posedge clk); #1;                                     // P+4
    check("hit_end", 32'(hit), 32'(0));
    check("hex_score", 32'(hex_score), 32'(exp_digit[exp_score]));
    repeat (hold) @(posedge clk);
    #1;
    check("one_capture", 32'(cap_cnt - base), 32'(1));
    key_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("back_idle", 32'(dut.state), 32'(IDLE));
  endtask

  initial begin
    logic found;
    int   base;
    nrst   = 1'b0;
    key_n  = 1'b1;
    seg_in = 7'h7F;
    guess  = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(dut.state), 32'(IDLE));
    check("rst_score", 32'(score), 32'(0));
    check("rst_hex", 32'(hex_score), 32'(7'b1000000));
    check("rst_pos", 32'(pos), 32'(0));
    check("rst_flags", 32'({pos_valid, hit, err}), 32'(0));
    @(negedge clk) nrst = 1'b1;
    @(posedge clk); #1;

    // Bounce: short lows never get through
    base = cap_cnt;
    for (int i = 0; i < 10; i++) begin
      key_n = 1'b0;
      repeat (5) @(posedge clk);
      key_n = 1'b1;
      repeat (5) @(posedge clk);
    end
    repeat (30) @(posedge clk);
    #1;
    check("bounce_no_capture", 32'(cap_cnt - base), 32'(0));

    // Hit: lit d -> position 3
    do_press(7'b1110111, 3'd3, 3'd3, 5);
    check("hit_hex_one", 32'(hex_score), 32'(7'b1111001));
    // Miss: lit a -> position 0, guess 2
    do_press(7'b1111110, 3'd2, 3'd0, 5);
    // Invalid: two lit segments
    do_press(7'b1110011, 3'd2, 3'd7, 5);
    // Invalid: g lit; guess 7 must not match
    do_press(7'b0111111, 3'd7, 3'd7, 5);

    // Saturate with position 5 hits; last one held 1000 cycles
    for (int i = 0; i < 11; i++) begin
      do_press(7'b1011111, 3'd5, 3'd5, (i == 10) ? 1000 : 5);
    end
    check("sat_score", 32'(score), 32'(9));
    check("sat_hex", 32'(hex_score), 32'(7'b0010000));

    // Async reset in HOLD
    seg_in = 7'b1111101;
    guess  = 3'd1;
    key_n  = 1'b0;
    wait_press(found);
    check("rst_press_seen", 32'(found), 32'(1));
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_hold", 32'(dut.state), 32'(HOLD));
    #2 nrst = 1'b0;
    #1;
    check("arst_state", 32'(dut.state), 32'(IDLE));
    check("arst_score", 32'(score), 32'(0));
    check("arst_hex", 32'(hex_score), 32'(7'b1000000));
    check("arst_flags", 32'({pos_valid, hit, err}), 32'(0));
    key_n = 1'b1;
    @(negedge clk) nrst = 1'b1;
    repeat (5) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
